dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipeline's load/store requests.
- Accepts the memRead/memWrite, WL and extendSign request produced by instruction decode, together with the ALU address and the store data.
- Performs byte, half or word accesses on an internal byte-addressable word memory with configurable access latency.
- Splits word-crossing accesses into two word accesses, stalls the pipeline until the access completes, and returns sign- or zero-extended load data.

Parameters:
DEPTH, 256, number of 32-bit words in the memory (power of 2)
LAT, 2, cycles per word access (minimum 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
memRead  input  1  load request
memWrite  input  1  store request
WL  input  2  access width: 0 byte, 1 half, 2 word, 3 illegal
extendSign  input  1  1 = sign-extend load, 0 = zero-extend
addr  input  32  byte address
wdata  input  32  store data, LSB-aligned
rdata  output  32  load result
stall  output  1  pipeline hold
done  output  1  one-cycle completion pulse
err  output  1  one-cycle illegal-request pulse, coincident with done

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE; stall, done, err = 0; rdata = 0; counter = 0. The memory array is not reset.
- Requests:
  - A request exists when memRead|memWrite is high.
  - A request is sampled only in IDLE. Inputs are held by the pipeline while stall=1.
  - The responder latches addr, wdata, WL, extendSign and direction on acceptance.
- stall = (IDLE && request) || ACC0 || ACC1. stall is 0 in RESP, so the pipeline advances on the edge ending RESP.
- States:
  - IDLE:
    - Legal request goes to ACC0 with counter = LAT-1.
    - Illegal request (memRead&memWrite, or WL=3) goes directly to RESP with err flagged.
  - ACC0: counts down. At counter = 0 it performs the first-word access.
    - If the access crosses a word boundary (addr[1:0] + size > 4; size 1/2/4 bytes), go to ACC1 with counter reloaded to LAT-1.
    - Otherwise go to RESP.
  - ACC1: counts down. At counter = 0 it performs the second-word access (word index + 1), then goes to RESP.
  - RESP: done = 1, err = 1 if the request was illegal. Next state is IDLE.
- Latency, with the request first present in cycle 0:
  - Aligned access: done in cycle 1+LAT.
  - Split access: done in cycle 1+2*LAT.
  - Illegal request: done in cycle 1.
- Addressing:
  - Word index = addr[log2(DEPTH)+1:2], modulo DEPTH.
  - For a split access, the second word is (index+1) mod DEPTH, so the last word wraps to word 0.
- Stores:
  - Per-byte write enables, little-endian: byte k of wdata goes to byte address addr+k.
  - Only the addressed bytes change.
  - The first-word bytes are committed in ACC0, the remaining bytes in ACC1.
- Loads:
  - Bytes are assembled little-endian from one or two words.
  - The value is extended from bit 7 (byte) or bit 15 (half) when extendSign = 1; otherwise it is zero-filled.
  - rdata updates on entry to RESP and holds until the next completed load.
  - Stores and illegal requests leave rdata unchanged.
- Reset mid-operation: an immediate return to IDLE. Bytes already committed in ACC0 persist, and the ACC1 bytes are not written.
- The request inputs are not sampled in ACC0, ACC1 or RESP.

Test Plan:
- LAT=2. SW 0xDEADBEEF at 0x10, then LW 0x10 → stall=1 in cycles 0–2, done in cycle 3, rdata=0xDEADBEEF, err=0.
- After that store:
  - LB 0x11 with extendSign=1 → rdata=0xFFFFFFBE.
  - LBU 0x11 → rdata=0x000000BE.
  - LH 0x12 signed → rdata=0xFFFFDEAD.
  - LHU 0x12 → rdata=0x0000DEAD.
- SW 0x11223344 at 0x14, then LW 0x13 (split) → done in cycle 5, rdata=0x223344DE. Words 0x10 and 0x14 are otherwise unchanged.
- Wrap test (DEPTH=256): SH 0xABCD at 0x3FF → byte 0x3FF=0xCD, byte 0x000=0xAB. LHU 0x3FF → 0x0000ABCD, with all neighbouring bytes unchanged.
- Illegal requests (memRead=memWrite=1, or memRead with WL=3) → done=err=1 in cycle 1, stall=1 only in cycle 0, memory and rdata unchanged.
- rst_n pulsed low during ACC1 of a split SW 0xCAFEF00D at 0x1E:
  - stall, done and rdata go to 0 immediately.
  - Bytes 0x1E/0x1F = 0x0D/0xF0 are written; bytes 0x20/0x21 keep their old values.
  - A following LW 0x20 completes normally.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response bundle between pipeline and data memory.
interface dmem_responder_if;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  WL;
    logic        extendSign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output memRead, memWrite, WL, extendSign, addr, wdata,
        input  rdata, stall, done, err
    );

    modport slave (
        input  memRead, memWrite, WL, extendSign, addr, wdata,
        output rdata, stall, done, err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte/half/word data memory with per-word latency, split word-crossing
// accesses, pipeline stall and sign/zero-extended load data.
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input logic           clk,
    input logic           rst_n,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(LAT - 1);

    logic [31:0]   mem [DEPTH];
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   lo_q;
    logic [31:0]   rdata_q;
    logic [1:0]    wl_q;
    logic          sext_q;
    logic          wr_q;
    logic          ill_q;

    logic          req;
    logic          illegal;
    logic [1:0]    off;
    logic [2:0]    size;
    logic [3:0]    mask;
    logic          split;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx1;
    logic [7:0]    be;
    logic [63:0]   wide;
    logic [63:0]   joined;
    logic [31:0]   sh;
    logic [31:0]   ld;
    logic          last;

    assign req     = bus.memRead | bus.memWrite;
    assign illegal = (bus.memRead & bus.memWrite) | (bus.WL == 2'd3);
    assign off     = addr_q[1:0];
    assign size    = (wl_q == 2'd0) ? 3'd1 : (wl_q == 2'd1) ? 3'd2 : 3'd4;
    assign mask    = (wl_q == 2'd0) ? 4'h1 : (wl_q == 2'd1) ? 4'h3 : 4'hF;
    assign split   = ({1'b0, off} + size) > 3'd4;
    assign idx     = addr_q[AW+1:2];
    assign idx1    = idx + AW'(1);
    assign last    = cnt_q == '0;

    // Store data and byte enables laid out across the two words the access may touch.
    assign be   = {4'b0, mask} << off;
    assign wide = {32'b0, wdata_q} << {off, 3'b000};

    // Load bytes: the first word is held in lo_q while the second word is being fetched.
    assign joined = (state_q == ACC1) ? {mem[idx1], lo_q} : {32'b0, mem[idx]};
    assign sh     = 32'(joined >> {off, 3'b000});
    assign ld     = (wl_q == 2'd0) ? {{24{sext_q & sh[7]}}, sh[7:0]} :
                    (wl_q == 2'd1) ? {{16{sext_q & sh[15]}}, sh[15:0]} : sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            wl_q    <= '0;
            sext_q  <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    addr_q  <= bus.addr[AW+1:0];
                    wdata_q <= bus.wdata;
                    wl_q    <= bus.WL;
                    sext_q  <= bus.extendSign;
                    wr_q    <= bus.memWrite;
                    ill_q   <= illegal;
                    cnt_q   <= RELOAD;
                    state_q <= illegal ? RESP : ACC0;
                end
                ACC0: if (!last) begin
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    lo_q    <= mem[idx];
                    cnt_q   <= RELOAD;
                    state_q <= split ? ACC1 : RESP;
                    if (!wr_q && !split) rdata_q <= ld;
                end
                ACC1: if (!last) begin
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    state_q <= RESP;
                    if (!wr_q) rdata_q <= ld;
                end
                RESP: state_q <= IDLE;
            endcase
        end
    end

    // Array is deliberately unreset; a reset during ACC1 simply never reaches the second write.
    always_ff @(posedge clk) begin
        if (wr_q && last) begin
            for (int k = 0; k < 4; k++) begin
                if (state_q == ACC0 && be[k]) mem[idx][8*k +: 8] <= wide[8*k +: 8];
                if (state_q == ACC1 && be[k+4]) mem[idx1][8*k +: 8] <= wide[32+8*k +: 8];
            end
        end
    end

    assign bus.stall = (state_q == IDLE && req) || state_q == ACC0 || state_q == ACC1;
    assign bus.done  = state_q == RESP;
    assign bus.err   = state_q == RESP && ill_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized load/store traffic checked against a byte-array model.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int NB    = DEPTH * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  ref_mem [NB];
    logic [31:0] exp_rd = '0;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input logic [1:0] wl);
        return (wl == 2'd0) ? 1 : (wl == 2'd1) ? 2 : 4;
    endfunction

    function automatic int unsigned bidx(input logic [31:0] a, input int k);
        return (a + 32'(k)) % 32'(NB);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] wl, input logic sx);
        logic [31:0] v = '0;
        for (int k = 0; k < sz(wl); k++) v[8*k +: 8] = ref_mem[bidx(a, k)];
        if (sx && wl == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (sx && wl == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [1:0] wl, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        int cyc = 0;
        int st = 0;
        int lat;
        logic ill;
        ill = (rd && wr) || wl == 2'd3;
        lat = ill ? 1 : ((a % 4) + 32'(sz(wl)) > 4) ? 1 + 2*LAT : 1 + LAT;
        @(negedge clk);
        bus.memRead = rd;
        bus.memWrite = wr;
        bus.WL = wl;
        bus.extendSign = sx;
        bus.addr = a;
        bus.wdata = d;
        #1;
        while (!bus.done && cyc < 40) begin
            st += int'(bus.stall);
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!ill && wr) for (int k = 0; k < sz(wl); k++) ref_mem[bidx(a, k)] = d[8*k +: 8];
        if (!ill && rd) exp_rd = model_load(a, wl, sx);
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        chk({tag, " stall_cycles"}, 32'(st), 32'(lat));
        chk({tag, " stall_at_done"}, {31'b0, bus.stall}, 32'd0);
        chk({tag, " err"}, {31'b0, bus.err}, {31'b0, ill});
        chk({tag, " rdata"}, bus.rdata, exp_rd);
        @(negedge clk);
        bus.memRead = 1'b0;
        bus.memWrite = 1'b0;
    endtask

    initial begin
        bus.memRead = 1'b0;
        bus.memWrite = 1'b0;
        bus.WL = 2'd0;
        bus.extendSign = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset stall", {31'b0, bus.stall}, 32'd0);
        chk("reset done", {31'b0, bus.done}, 32'd0);
        chk("reset err", {31'b0, bus.err}, 32'd0);
        chk("reset rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++) access(1'b0, 1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, "init");

        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw10");
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10");
        chk("lw10 value", bus.rdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, "lb11");
        chk("lb11 value", bus.rdata, 32'hFFFFFFBE);
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, "lbu11");
        chk("lbu11 value", bus.rdata, 32'h000000BE);
        access(1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "lh12");
        chk("lh12 value", bus.rdata, 32'hFFFFDEAD);
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "lhu12");
        chk("lhu12 value", bus.rdata, 32'h0000DEAD);
        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h14, 32'h11223344, "sw14");
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, "lw13split");
        chk("lw13 value", bus.rdata, 32'h223344DE);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, "lw14");
        chk("lw14 value", bus.rdata, 32'h11223344);

        access(1'b0, 1'b1, 2'd1, 1'b0, 32'h3FF, 32'h0000ABCD, "sh3ff");
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0, "lhu3ff");
        chk("lhu3ff value", bus.rdata, 32'h0000ABCD);
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0, "lbu3ff");
        chk("lbu3ff value", bus.rdata, 32'h000000CD);
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h000, 32'h0, "lbu000");
        chk("lbu000 value", bus.rdata, 32'h000000AB);
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h3FE, 32'h0, "lbu3fe");
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h001, 32'h0, "lbu001");

        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10again");
        access(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h55555555, "illegal_rw");
        access(1'b1, 1'b0, 2'd3, 1'b1, 32'h14, 32'h0, "illegal_wl3");
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h14, 32'h66666666, "illegal_sw3");
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10after");
        chk("lw10after value", bus.rdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, "lw14after");
        chk("lw14after value", bus.rdata, 32'h11223344);

        // split store interrupted by reset during its second word
        @(negedge clk);
        bus.memRead = 1'b0;
        bus.memWrite = 1'b1;
        bus.WL = 2'd2;
        bus.addr = 32'h1E;
        bus.wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        chk("rst stall_in_acc1", {31'b0, bus.stall}, 32'd1);
        rst_n = 1'b0;
        bus.memWrite = 1'b0;
        #1;
        chk("rst stall", {31'b0, bus.stall}, 32'd0);
        chk("rst done", {31'b0, bus.done}, 32'd0);
        chk("rst rdata", bus.rdata, 32'd0);
        ref_mem[32'h1E] = 8'h0D;
        ref_mem[32'h1F] = 8'hF0;
        exp_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h1E, 32'h0, "lbu1e");
        chk("lbu1e value", bus.rdata, 32'h0000000D);
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h1F, 32'h0, "lbu1f");
        chk("lbu1f value", bus.rdata, 32'h000000F0);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw20");

        for (int i = 0; i < 250; i++) begin
            logic rd, wr;
            logic [1:0] wl;
            int r = int'($urandom_range(0, 19));
            rd = (r == 0) || r[0];
            wr = (r == 0) || !r[0];
            wl = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            access(rd, wr, wl, 1'($urandom), $urandom, $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
